// File: rtl/cache_parameters.sv
// Shared cache/memory types for the I/D cache pair and the Wishbone block master.
// No logic; pure type and constant definitions.
// Flow control is cs-level / ack-pulse between cache, arbiter and master.
package cache_parameters;

  localparam int WORD_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int BLOCK_SIZE   = 4;
  localparam int OFFSET_WIDTH = 2;

  // Block request from a cache; rw=1 is a write of the whole block.
  typedef struct packed {
    logic                                  cs;
    logic                                  rw;
    logic [ADDR_WIDTH-1:0]                 addr;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_request_t;

  // Block response; ack pulses for one cycle when the block transfer ends.
  typedef struct packed {
    logic                                  ack;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_response_t;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_ICACHE = 2'd1,
    GNT_DCACHE = 2'd2
  } mem_grant_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wshbn_cache_arbiter.sv
// Shares one Wishbone block master between the I-cache and the D-cache.
// Latency: cs sampled at edge N -> mem_req_o.cs from cycle N+1; ack passes through combinationally.
// Backpressure: a losing requester holds cs and is served on the next ARB_IDLE; 2-cycle issue gap.
module wshbn_cache_arbiter
  import cache_parameters::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  memory_request_t  ireq_i,
  output memory_response_t ires_o,
  input  memory_request_t  dreq_i,
  output memory_response_t dres_o,
  output memory_request_t  mem_req_o,
  input  memory_response_t mem_res_i,
  output mem_grant_t       grant_o,
  output logic             busy_o
);

  arb_state_t      state, state_nx;
  memory_request_t req_q, req_nx;
  mem_grant_t      grant, grant_nx;
  mem_grant_t      last_gnt, last_nx;
  mem_grant_t      winner;

  // Winner of the current idle-cycle requests; ties go to D (fixed) or away from last owner.
  function automatic mem_grant_t pick_winner(input logic i_cs, input logic d_cs,
                                             input mem_grant_t last, input logic fixed_prio);
    if (i_cs && d_cs) begin
      if (fixed_prio)
        return GNT_DCACHE;
      else
        return (last == GNT_ICACHE) ? GNT_DCACHE : GNT_ICACHE;
    end else if (i_cs) begin
      return GNT_ICACHE;
    end else if (d_cs) begin
      return GNT_DCACHE;
    end
    return GNT_NONE;
  endfunction

  assign winner = pick_winner(ireq_i.cs, dreq_i.cs, last_gnt, FIXED_PRIO);

  // State, latched request and ownership registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= ARB_IDLE;
      req_q    <= '0;
      grant    <= GNT_NONE;
      last_gnt <= GNT_DCACHE;
    end else begin
      state    <= state_nx;
      req_q    <= req_nx;
      grant    <= grant_nx;
      last_gnt <= last_nx;
    end
  end

  // Next-state decode, master request drive and ack steering.
  always_comb begin
    state_nx     = state;
    req_nx       = req_q;
    grant_nx     = grant;
    last_nx      = last_gnt;
    mem_req_o    = req_q;
    mem_req_o.cs = 1'b0;
    ires_o.data  = mem_res_i.data;
    dres_o.data  = mem_res_i.data;
    ires_o.ack   = 1'b0;
    dres_o.ack   = 1'b0;

    case (state)
      ARB_IDLE: begin
        // Requester fields are only looked at here; the transfer runs from req_q.
        if (winner != GNT_NONE) begin
          req_nx   = (winner == GNT_ICACHE) ? ireq_i : dreq_i;
          grant_nx = winner;
          state_nx = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req_o.cs = 1'b1;
        if (mem_res_i.ack) begin
          // Ack is steered to the owner only; it is suppressed while reset is applied.
          ires_o.ack = (grant == GNT_ICACHE) && !RST_I;
          dres_o.ack = (grant == GNT_DCACHE) && !RST_I;
          last_nx    = grant;
          grant_nx   = GNT_NONE;
          state_nx   = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        // One cycle with cs low so the master drops back to idle before the next issue.
        grant_nx = GNT_NONE;
        state_nx = ARB_IDLE;
      end
      default: begin
        grant_nx = GNT_NONE;
        state_nx = ARB_IDLE;
      end
    endcase
  end

  assign grant_o = grant;
  assign busy_o  = (state != ARB_IDLE);

endmodule

// File: tb/tb_wshbn_cache_arbiter.sv
// Bench for wshbn_cache_arbiter: two instances (round-robin, fixed priority) each with a block-master/RAM model.
// Expected acks/beats are queued when requests are driven and popped as the DUT/master produce them.
// Requesters hold cs until ack, then stay low for three cycles before the next request.
module tb_wshbn_cache_arbiter;
  import cache_parameters::*;

  logic clk;
  logic rst;
  logic sel_fp;
  logic rst0, rst1;

  memory_request_t  ireq, dreq;
  memory_request_t  mreq0, mreq1;
  memory_response_t ires0, ires1, dres0, dres1, mres0, mres1;
  mem_grant_t       gnt0, gnt1;
  logic             bsy0, bsy1;

  memory_response_t cur_ires, cur_dres;
  memory_request_t  cur_mreq;
  mem_grant_t       cur_gnt;
  logic             cur_bsy;

  int n_err = 0;
  int n_chk = 0;
  int beat_cnt = 0;
  bit chk_beats = 0;
  bit prev_ack = 0;

  typedef struct {
    int           port;
    bit           is_rd;
    logic [127:0] data;
  } exp_ack_t;

  exp_ack_t    ack_q[$];
  logic [32:0] beat_q[$];
  logic [31:0] shadow [int];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rst0 = rst | sel_fp;
  assign rst1 = rst | ~sel_fp;

  wshbn_cache_arbiter #(.FIXED_PRIO(1'b0)) u_dut_rr (
    .CLK_I(clk), .RST_I(rst0),
    .ireq_i(ireq), .ires_o(ires0),
    .dreq_i(dreq), .dres_o(dres0),
    .mem_req_o(mreq0), .mem_res_i(mres0),
    .grant_o(gnt0), .busy_o(bsy0)
  );

  wshbn_cache_arbiter #(.FIXED_PRIO(1'b1)) u_dut_fp (
    .CLK_I(clk), .RST_I(rst1),
    .ireq_i(ireq), .ires_o(ires1),
    .dreq_i(dreq), .dres_o(dres1),
    .mem_req_o(mreq1), .mem_res_i(mres1),
    .grant_o(gnt1), .busy_o(bsy1)
  );

  assign cur_ires = sel_fp ? ires1 : ires0;
  assign cur_dres = sel_fp ? dres1 : dres0;
  assign cur_mreq = sel_fp ? mreq1 : mreq0;
  assign cur_gnt  = sel_fp ? gnt1  : gnt0;
  assign cur_bsy  = sel_fp ? bsy1  : bsy0;

  function automatic logic [31:0] init_word(input int a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Block master + RAM model: registers cs, then 4 beats (one per cycle), then a 1-cycle ack.
  for (genvar g = 0; g < 2; g++) begin : g_m
    logic [31:0]      ram [1024];
    logic [1:0]       ms;
    logic [1:0]       beat;
    logic             stb, we;
    logic [31:0]      adr;
    memory_response_t res;
    memory_request_t  mq;
    logic             mrst;
    logic [31:0]      cur_a;

    assign mq    = (g == 0) ? mreq0 : mreq1;
    assign mrst  = (g == 0) ? rst0 : rst1;
    assign cur_a = mq.addr + {30'd0, beat};

    initial begin
      for (int a = 0; a < 1024; a++) ram[a] = init_word(a);
    end

    // Wishbone-style block engine of the master, sharing the arbiter's reset.
    always @(posedge clk) begin
      stb <= 1'b0;
      if (mrst) begin
        ms      <= 2'd0;
        beat    <= 2'd0;
        res.ack <= 1'b0;
      end else begin
        case (ms)
          2'd0: if (mq.cs) begin ms <= 2'd1; beat <= 2'd0; end
          2'd1: begin
            stb <= 1'b1;
            adr <= cur_a;
            we  <= mq.rw;
            if (mq.rw) ram[cur_a[9:0]] <= mq.data[beat];
            else       res.data[beat] <= ram[cur_a[9:0]];
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin ms <= 2'd2; res.ack <= 1'b1; end
          end
          default: begin res.ack <= 1'b0; ms <= 2'd0; end
        endcase
      end
    end
  end

  assign mres0 = g_m[0].res;
  assign mres1 = g_m[1].res;

  // Beat monitor on the round-robin instance's master.
  always @(negedge clk) begin
    if (g_m[0].stb === 1'b1) begin
      beat_cnt++;
      if (chk_beats) begin
        if (beat_q.size() == 0) chk("beat_extra", 1, 0);
        else chk("beat_we_adr", {g_m[0].we, g_m[0].adr}, beat_q.pop_front());
      end
    end
  end

  // Ack scoreboard plus release-cycle check on the selected instance.
  always @(negedge clk) begin
    exp_ack_t e;
    if (prev_ack) begin
      chk("rel_cs", cur_mreq.cs, 0);
      chk("rel_gnt", cur_gnt, GNT_NONE);
      chk("rel_busy", cur_bsy, 1);
    end
    prev_ack <= 1'b0;
    if (cur_ires.ack === 1'b1 && cur_dres.ack === 1'b1) begin
      chk("dual_ack", 1, 0);
    end else if (cur_ires.ack === 1'b1 || cur_dres.ack === 1'b1) begin
      prev_ack <= 1'b1;
      if (ack_q.size() == 0) begin
        chk("stray_ack", 1, 0);
      end else begin
        e = ack_q.pop_front();
        chk("ack_port", cur_ires.ack ? 1 : 2, e.port);
        chk("ack_grant", cur_gnt, e.port);
        if (e.is_rd) chk("ack_data", cur_ires.ack ? cur_ires.data : cur_dres.data, e.data);
      end
    end
  end

  function automatic exp_ack_t mk_exp(input int port, input logic rw, input logic [31:0] addr);
    exp_ack_t e;
    e.port  = port;
    e.is_rd = !rw;
    e.data  = '0;
    for (int b = 0; b < 4; b++) e.data[32*b +: 32] = exp_word(int'(addr) + b);
    return e;
  endfunction

  // Issue one block request on port 1 (I) or 2 (D) and hold it until its ack.
  task automatic do_req(input int port, input logic [31:0] addr, input logic rw,
                        input logic [127:0] wdata, input bit push,
                        input int chg_at, input logic [31:0] alt_addr);
    memory_request_t r;
    bit ok;
    logic a;
    r.cs = 1'b1; r.rw = rw; r.addr = addr; r.data = wdata;
    if (rw) begin
      for (int b = 0; b < 4; b++) shadow[int'(addr) + b] = wdata[32*b +: 32];
    end
    if (push) ack_q.push_back(mk_exp(port, rw, addr));
    if (chk_beats) begin
      for (int b = 0; b < 4; b++) beat_q.push_back({rw, addr + 32'(b)});
    end
    if (port == 1) ireq = r; else dreq = r;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (chg_at != 0 && k + 1 == chg_at) begin
        if (port == 1) ireq.addr = alt_addr; else dreq.addr = alt_addr;
      end
      a = (port == 1) ? cur_ires.ack : cur_dres.ack;
      if (a === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ack_timeout", 0, 1);
    if (port == 1) ireq.cs = 1'b0; else dreq.cs = 1'b0;
  endtask

  task automatic tie_run;
    fork
      begin
        for (int n = 0; n < 3; n++) begin
          do_req(1, 32'h10, 1'b0, '0, 1'b0, 0, '0);
          repeat (3) @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 3; n++) begin
          do_req(2, 32'h20, 1'b0, '0, 1'b0, 0, '0);
          repeat (3) @(negedge clk);
        end
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bit seen;
    sel_fp = 1'b0;
    rst    = 1'b1;
    ireq   = '0;
    dreq   = '0;
    ireq.cs = 1'b1;
    dreq.cs = 1'b1;

    // Reset held three cycles with both requests asserted.
    repeat (3) @(negedge clk);
    chk("rst_cs", mreq0.cs, 0);
    chk("rst_gnt", gnt0, GNT_NONE);
    chk("rst_iack", ires0.ack, 0);
    chk("rst_dack", dres0.ack, 0);
    chk("rst_busy", bsy0, 0);
    ireq.cs = 1'b0;
    dreq.cs = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", bsy0, 0);

    // I-only read, D-only write, D read-back of the written block.
    chk_beats = 1'b1;
    do_req(1, 32'h100, 1'b0, '0, 1'b1, 0, '0);
    repeat (3) @(negedge clk);
    do_req(2, 32'h200, 1'b1, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 1'b1, 0, '0);
    repeat (8) @(negedge clk);
    chk("wr_idle_busy", bsy0, 0);
    do_req(2, 32'h200, 1'b0, '0, 1'b1, 0, '0);
    repeat (3) @(negedge clk);

    // D moves its address mid-transfer; beats must still use the latched address.
    do_req(2, 32'h20, 1'b0, '0, 1'b1, 3, 32'h40);
    repeat (3) @(negedge clk);
    chk_beats = 1'b0;

    // Simultaneous requests, round-robin: I,D,I,D,I,D.
    for (int n = 0; n < 3; n++) begin
      ack_q.push_back(mk_exp(1, 1'b0, 32'h10));
      ack_q.push_back(mk_exp(2, 1'b0, 32'h20));
    end
    tie_run();
    repeat (3) @(negedge clk);
    chk("rr_q_empty", ack_q.size(), 0);

    // Same stimulus on the fixed-priority instance: D,I,D,I,D,I.
    sel_fp = 1'b1;
    repeat (3) @(negedge clk);
    chk("fp_idle_gnt", gnt1, GNT_NONE);
    for (int n = 0; n < 3; n++) begin
      ack_q.push_back(mk_exp(2, 1'b0, 32'h20));
      ack_q.push_back(mk_exp(1, 1'b0, 32'h10));
    end
    tie_run();
    repeat (3) @(negedge clk);
    chk("fp_q_empty", ack_q.size(), 0);
    sel_fp = 1'b0;
    repeat (3) @(negedge clk);

    // Reset pulse during the second beat of an I read: no ack, then a clean re-issue.
    start = beat_cnt;
    seen  = 1'b0;
    ireq.cs = 1'b1; ireq.rw = 1'b0; ireq.addr = 32'h100; ireq.data = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (beat_cnt - start >= 2) begin seen = 1'b1; break; end
    end
    chk("t6_beats_seen", seen, 1);
    rst = 1'b1;
    ireq.cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_cs", mreq0.cs, 0);
    chk("t6_busy", bsy0, 0);
    chk("t6_gnt", gnt0, GNT_NONE);
    repeat (10) @(negedge clk);
    chk("t6_no_beats", beat_cnt - start <= 3, 1);
    chk_beats = 1'b1;
    do_req(1, 32'h100, 1'b0, '0, 1'b1, 0, '0);
    repeat (4) @(negedge clk);

    chk("ack_q_empty", ack_q.size(), 0);
    chk("beat_q_empty", beat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
